spi_burst_ctrl: RTL and testbench

- Front-end sequencer that sits directly upstream of the byte-level SPI master.
- Buffers host TX bytes in a TX FIFO and issues one start pulse per byte to the master.
- Captures each received byte into an RX FIFO.
- Runs a burst of N bytes back-to-back without host intervention, then pulses done.

---
 rtl/spi_burst_ctrl_if.sv | 38 +++
 rtl/spi_burst_ctrl.sv | 139 +++++++++++++
 tb/tb_spi_burst_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_burst_ctrl_if.sv
// Signal bundle between spi_burst_ctrl, its host and the byte-level SPI master.
// The controller connects through the slave modport; the host/SPI side uses the master modport.
interface spi_burst_ctrl_if #(
   parameter int ADDR_W = 3
);
   logic              tx_wr_en;
   logic [7:0]        tx_wr_data;
   logic              tx_full;
   logic [ADDR_W:0]   tx_count;
   logic              rx_rd_en;
   logic [7:0]        rx_rd_data;
   logic              rx_empty;
   logic [ADDR_W:0]   rx_count;
   logic              go;
   logic [7:0]        burst_len;
   logic              active;
   logic              done;
   logic              rx_overflow;
   logic              spi_start;
   logic [7:0]        spi_tx_data;
   logic              spi_busy;
   logic [7:0]        spi_rx_data;
   logic              spi_rx_valid;

   modport slave (
      input  tx_wr_en, tx_wr_data, rx_rd_en, go, burst_len,
             spi_busy, spi_rx_data, spi_rx_valid,
      output tx_full, tx_count, rx_rd_data, rx_empty, rx_count,
             active, done, rx_overflow, spi_start, spi_tx_data
   );

   modport master (
      output tx_wr_en, tx_wr_data, rx_rd_en, go, burst_len,
             spi_busy, spi_rx_data, spi_rx_valid,
      input  tx_full, tx_count, rx_rd_data, rx_empty, rx_count,
             active, done, rx_overflow, spi_start, spi_tx_data
   );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of a byte SPI master: TX FIFO feeds one start pulse per byte,
// each received byte lands in an RX FIFO, and done pulses after burst_len bytes (0 = 256).
module spi_burst_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 3
) (
   input  logic            clk,
   input  logic            reset,
   spi_burst_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RX, WAIT_IDLE, FINISH} state_t;

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);

   state_t            state_q, state_d;
   logic [8:0]        remaining_q, remaining_d;
   logic              rx_ovf_q, rx_ovf_d;
   logic [7:0]        tx_last_q;

   logic [7:0]        tx_mem_q [FIFO_DEPTH];
   logic [7:0]        rx_mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
   logic [ADDR_W:0]   tx_cnt_q, rx_cnt_q;

   logic tx_empty, tx_full, rx_empty, rx_full;
   logic tx_push, tx_pop, rx_push, rx_pop, rx_req;

   assign tx_empty = (tx_cnt_q == '0);
   assign tx_full  = (tx_cnt_q == FULL_CNT);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == FULL_CNT);

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign tx_push = bus.tx_wr_en && (!tx_full || tx_pop);
   assign rx_pop  = bus.rx_rd_en && !rx_empty;
   assign rx_push = rx_req && (!rx_full || rx_pop);

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      rx_ovf_d    = rx_ovf_q;
      tx_pop      = 1'b0;
      rx_req      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.go) begin
               remaining_d = (bus.burst_len == 8'd0) ? 9'd256 : {1'b0, bus.burst_len};
               rx_ovf_d    = 1'b0;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (!tx_empty && !bus.spi_busy) begin
               tx_pop      = 1'b1;
               remaining_d = remaining_q - 9'd1;
               state_d     = WAIT_RX;
            end
         end
         WAIT_RX: begin
            if (bus.spi_rx_valid) begin
               rx_req = 1'b1;
               if (rx_full && !bus.rx_rd_en) begin
                  rx_ovf_d = 1'b1;
               end
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            if (!bus.spi_busy) begin
               state_d = (remaining_q != 9'd0) ? ISSUE : FINISH;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         rx_ovf_q    <= 1'b0;
         tx_last_q   <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         rx_ovf_q    <= rx_ovf_d;
         if (tx_pop) begin
            tx_last_q <= tx_mem_q[tx_rptr_q];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            tx_mem_q[i] <= '0;
            rx_mem_q[i] <= '0;
         end
      end else begin
         if (tx_push) begin
            tx_mem_q[tx_wptr_q] <= bus.tx_wr_data;
         end
         if (rx_push) begin
            rx_mem_q[rx_wptr_q] <= bus.spi_rx_data;
         end
      end
   end

   // Pointers are ADDR_W bits wide, so they wrap modulo FIFO_DEPTH on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         tx_cnt_q  <= '0;
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         rx_cnt_q  <= '0;
      end else begin
         tx_wptr_q <= tx_wptr_q + ADDR_W'(tx_push);
         tx_rptr_q <= tx_rptr_q + ADDR_W'(tx_pop);
         tx_cnt_q  <= tx_cnt_q + (ADDR_W+1)'(tx_push) - (ADDR_W+1)'(tx_pop);
         rx_wptr_q <= rx_wptr_q + ADDR_W'(rx_push);
         rx_rptr_q <= rx_rptr_q + ADDR_W'(rx_pop);
         rx_cnt_q  <= rx_cnt_q + (ADDR_W+1)'(rx_push) - (ADDR_W+1)'(rx_pop);
      end
   end

   assign bus.tx_full     = tx_full;
   assign bus.tx_count    = tx_cnt_q;
   assign bus.rx_empty    = rx_empty;
   assign bus.rx_count    = rx_cnt_q;
   assign bus.rx_rd_data  = rx_mem_q[rx_rptr_q];
   assign bus.active      = (state_q != IDLE);
   assign bus.done        = (state_q == FINISH);
   assign bus.rx_overflow = rx_ovf_q;
   assign bus.spi_start   = tx_pop;
   assign bus.spi_tx_data = tx_pop ? tx_mem_q[tx_rptr_q] : tx_last_q;
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Scoreboard bench for spi_burst_ctrl: queue-based FIFO/burst model checked at every negedge,
// with an SPI master model that answers each start with the inverted byte after random latency.
module tb_spi_burst_ctrl;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic busy_int = 1'b0;
   logic force_busy = 1'b0;
   logic rx_resp = 1'b0;
   bit   rand_host = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int start_cnt = 0;
   int done_cnt = 0;

   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   bit         model_active = 1'b0;
   int         model_rem = 0;
   bit         model_ovf = 1'b0;

   always #5 clk = ~clk;

   spi_burst_ctrl_if #(.ADDR_W(3)) bus ();

   spi_burst_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.spi_busy = busy_int | force_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: compare outputs against the state left by the previous edge, then apply this cycle's events.
   always @(negedge clk) begin
      if (reset) begin
         tx_q.delete();
         rx_q.delete();
         model_active = 1'b0;
         model_rem    = 0;
         model_ovf    = 1'b0;
      end else begin
         chk("tx_count", 32'(bus.tx_count), 32'(tx_q.size()));
         chk("rx_count", 32'(bus.rx_count), 32'(rx_q.size()));
         chk("tx_full", 32'(bus.tx_full), 32'(tx_q.size() == DEPTH));
         chk("rx_empty", 32'(bus.rx_empty), 32'(rx_q.size() == 0));
         chk("rx_overflow", 32'(bus.rx_overflow), 32'(model_ovf));
         chk("active", 32'(bus.active), 32'(model_active));
         if (bus.spi_start) begin
            start_cnt++;
            chk("start_allowed", 32'(model_active && model_rem > 0 && tx_q.size() > 0 && !bus.spi_busy), 32'd1);
            if (tx_q.size() > 0) begin
               chk("spi_tx_data", 32'(bus.spi_tx_data), 32'(tx_q[0]));
               void'(tx_q.pop_front());
            end
            if (model_rem > 0) model_rem--;
         end
         if (bus.tx_wr_en && tx_q.size() < DEPTH) tx_q.push_back(bus.tx_wr_data);
         if (bus.rx_rd_en && rx_q.size() > 0) begin
            chk("rx_rd_data", 32'(bus.rx_rd_data), 32'(rx_q[0]));
            void'(rx_q.pop_front());
         end
         if (bus.spi_rx_valid && rx_resp) begin
            if (rx_q.size() < DEPTH) rx_q.push_back(bus.spi_rx_data);
            else model_ovf = 1'b1;
         end
         if (bus.go && !model_active) begin
            model_active = 1'b1;
            model_rem    = (bus.burst_len == 8'd0) ? 256 : int'(bus.burst_len);
            model_ovf    = 1'b0;
         end
         if (bus.done) begin
            done_cnt++;
            chk("done_expected", 32'(model_active && model_rem == 0 && !busy_int), 32'd1);
            model_active = 1'b0;
         end
      end
   end

   initial begin : spi_master
      logic [7:0] b;
      int lat;
      bus.spi_rx_valid = 1'b0;
      bus.spi_rx_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.spi_start && !reset) begin
            b = bus.spi_tx_data;
            @(posedge clk);
            #1 busy_int = 1'b1;
            lat = $urandom_range(0, 3);
            if (lat > 0) begin
               repeat (lat) @(posedge clk);
               #1;
            end
            bus.spi_rx_data  = ~b;
            bus.spi_rx_valid = 1'b1;
            rx_resp          = 1'b1;
            @(posedge clk);
            #1;
            bus.spi_rx_valid = 1'b0;
            rx_resp          = 1'b0;
            busy_int         = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      bus.tx_wr_en   = 1'b1;
      bus.tx_wr_data = d;
      tick();
      bus.tx_wr_en = 1'b0;
   endtask

   task automatic start_burst(input logic [7:0] len);
      bus.go        = 1'b1;
      bus.burst_len = len;
      tick();
      bus.go = 1'b0;
   endtask

   task automatic read_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.rx_rd_en = 1'b1;
         tick();
      end
      bus.rx_rd_en = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int d0;
      int k;
      d0 = done_cnt;
      k  = 0;
      while (done_cnt == d0 && k < budget) begin
         if (rand_host) begin
            bus.tx_wr_en   = ($urandom_range(0, 2) == 0);
            bus.tx_wr_data = 8'($urandom);
            bus.rx_rd_en   = ($urandom_range(0, 1) == 1);
         end
         tick();
         k++;
      end
      bus.tx_wr_en = 1'b0;
      bus.rx_rd_en = 1'b0;
      vectors++;
      if (done_cnt == d0) begin
         miscompares++;
         $display("FAIL %s: got no done pulse, expected one within %0d cycles", tag, budget);
      end
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int s0;
      int k;
      bus.tx_wr_en   = 1'b0;
      bus.tx_wr_data = 8'h00;
      bus.rx_rd_en   = 1'b0;
      bus.go         = 1'b0;
      bus.burst_len  = 8'h00;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
      chk("rst_tx_count", 32'(bus.tx_count), 32'd0);
      chk("rst_tx_full", 32'(bus.tx_full), 32'd0);
      chk("rst_spi_start", 32'(bus.spi_start), 32'd0);
      chk("rst_active", 32'(bus.active), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_rx_overflow", 32'(bus.rx_overflow), 32'd0);
      chk("rst_spi_tx_data", 32'(bus.spi_tx_data), 32'd0);
      tick();

      // Two-byte burst with start latency check
      push(8'hA5);
      push(8'h3C);
      s0 = start_cnt;
      start_burst(8'd2);
      @(negedge clk);
      chk("go_latency_start", 32'(bus.spi_start), 32'd1);
      chk("first_tx_byte", 32'(bus.spi_tx_data), 32'hA5);
      tick();
      wait_done(100, "burst2");
      chk("burst2_starts", 32'(start_cnt - s0), 32'd2);
      chk("burst2_tx_count", 32'(bus.tx_count), 32'd0);
      chk("burst2_rx_head0", 32'(bus.rx_rd_data), 32'h5A);
      read_n(1);
      chk("burst2_rx_head1", 32'(bus.rx_rd_data), 32'hC3);
      read_n(1);

      // Underrun stall and resume
      push(8'h11);
      s0 = start_cnt;
      start_burst(8'd3);
      repeat (30) tick();
      chk("stall_starts", 32'(start_cnt - s0), 32'd1);
      chk("stall_active", 32'(bus.active), 32'd1);
      push(8'h22);
      push(8'h33);
      wait_done(100, "stall_resume");
      chk("stall_rx_count", 32'(bus.rx_count), 32'd3);
      read_n(3);

      // RX overflow
      for (int i = 0; i < 7; i++) push(8'($urandom));
      start_burst(8'd7);
      wait_done(200, "fill7");
      chk("fill7_rx_count", 32'(bus.rx_count), 32'd7);
      for (int i = 0; i < 3; i++) push(8'($urandom));
      start_burst(8'd3);
      wait_done(100, "overflow");
      chk("ovf_flag", 32'(bus.rx_overflow), 32'd1);
      chk("ovf_rx_count", 32'(bus.rx_count), 32'd8);
      push(8'h77);
      start_burst(8'd1);
      @(negedge clk);
      chk("ovf_cleared_by_go", 32'(bus.rx_overflow), 32'd0);
      wait_done(100, "ovf_again");
      read_n(8);

      // TX full, 256-byte burst stalls after 8, reset mid-burst
      for (int i = 0; i < 9; i++) push(8'(i * 29 + 5));
      chk("txfull_flag", 32'(bus.tx_full), 32'd1);
      chk("txfull_count", 32'(bus.tx_count), 32'd8);
      s0 = start_cnt;
      start_burst(8'd0);
      k = 0;
      while (start_cnt - s0 < 8 && k < 300) begin
         tick();
         k++;
      end
      repeat (20) tick();
      chk("len0_starts", 32'(start_cnt - s0), 32'd8);
      chk("len0_stalled_active", 32'(bus.active), 32'd1);
      chk("len0_rx_count", 32'(bus.rx_count), 32'd8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_active", 32'(bus.active), 32'd0);
      chk("midrst_tx_count", 32'(bus.tx_count), 32'd0);
      chk("midrst_rx_count", 32'(bus.rx_count), 32'd0);
      s0 = start_cnt;
      repeat (10) tick();
      chk("midrst_no_start", 32'(start_cnt - s0), 32'd0);

      // Busy held high at go; second go mid-burst ignored
      push(8'h5C);
      push(8'hC5);
      force_busy = 1'b1;
      s0 = start_cnt;
      start_burst(8'd2);
      repeat (10) tick();
      chk("busy_withheld", 32'(start_cnt - s0), 32'd0);
      force_busy = 1'b0;
      tick();
      chk("busy_active", 32'(bus.active), 32'd1);
      start_burst(8'd5);
      wait_done(100, "busy_burst");
      chk("busy_burst_starts", 32'(start_cnt - s0), 32'd2);
      read_n(2);

      // Randomized bursts with concurrent host traffic
      rand_host = 1'b1;
      for (int n = 0; n < 15; n++) begin
         start_burst(8'($urandom_range(1, 10)));
         wait_done(800, "random_burst");
      end
      rand_host = 1'b0;
      read_n(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
